// File: rtl/comparador_pkg.sv
// comparador_pkg
// Shared definitions for the serial magnitude comparator: FSM state type and
// the default values of the comparator parameters.
package comparador_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        CALCULO,
        FIN
    } estado_t;

    localparam int unsigned ANCHO_DEF      = 8;
    localparam int unsigned PASO_DEF       = 1;
    localparam logic        ESTADO_INI_DEF = 1'b0;

endpackage

// File: rtl/celda_paso_d_i.sv
// celda_paso_d_i
// Combinational chain of PASO comparator bit cells, bit 0 first.
// Each cell propagates x' = (~a & b) | (x & ~a) | (x & b), i.e. after the
// chain x_out is 1 when the processed slice of A is below that of B, or the
// slices are equal and x_in was 1.
// Ports:
//   a, b   [PASO-1:0] operand slices (LSB processed first)
//   x_in              carry into the least significant cell
//   x_out             carry out of the most significant cell
module celda_paso_d_i #(
    parameter int unsigned PASO = 1
) (
    input  logic [PASO-1:0] a,
    input  logic [PASO-1:0] b,
    input  logic            x_in,
    output logic            x_out
);

    logic x;

    always_comb begin
        x = x_in;
        for (int unsigned i = 0; i < PASO; i++) begin
            x = (~a[i] & b[i]) | (x & ~a[i]) | (x & b[i]);
        end
        x_out = x;
    end

endmodule

// File: rtl/comparador_serie_d_i.sv
// comparador_serie_d_i
// Serial magnitude comparator, LSB first, PASO bits per cycle.
// On an accepted inicio both operands are captured and shifted through
// celda_paso_d_i for ANCHO/PASO cycles; the final carry is presented on p_x
// with a one-cycle valido pulse.
// Optional feature: define COMPARADOR_IGUAL_EN to build the equality flag
// driving igual; without it igual is tied to 0.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   inicio        start request, sampled only while listo=1
//   a_p, b_p      operands A and B [ANCHO-1:0]
//   listo         idle, ready to accept inicio
//   valido        one-cycle pulse, p_x/igual valid
//   p_x           1 when A<B, or A==B and ESTADO_INI=1 (held until next result)
//   igual         1 when A==B (held until next result)
module comparador_serie_d_i
    import comparador_pkg::*;
#(
    parameter int unsigned ANCHO      = ANCHO_DEF,
    parameter int unsigned PASO       = PASO_DEF,
    parameter logic        ESTADO_INI = ESTADO_INI_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [ANCHO-1:0] a_p,
    input  logic [ANCHO-1:0] b_p,
    output logic             listo,
    output logic             valido,
    output logic             p_x,
    output logic             igual
);

    localparam int unsigned CICLOS = ANCHO / PASO;
    localparam int unsigned CW     = $clog2(CICLOS + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS - 1);

    generate
        if (ANCHO < 2 || PASO < 1 || (ANCHO % PASO) != 0) begin : g_param_chk
            $error("comparador_serie_d_i: ANCHO must be >= 2 and a multiple of PASO");
        end
    endgenerate

    estado_t          estado, estado_sig;
    logic [ANCHO-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic             x_q, x_sig;
    logic             p_x_q;
    logic             acepta, ultimo;

    celda_paso_d_i #(.PASO(PASO)) u_celdas (
        .a     (a_q[PASO-1:0]),
        .b     (b_q[PASO-1:0]),
        .x_in  (x_q),
        .x_out (x_sig)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= REPOSO;
        else     estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        listo      = 1'b0;
        valido     = 1'b0;
        acepta     = 1'b0;
        ultimo     = 1'b0;
        case (estado)
            REPOSO: begin
                listo = 1'b1;
                if (inicio) begin
                    acepta     = 1'b1;
                    estado_sig = CALCULO;
                end
            end
            CALCULO: begin
                if (cnt == ULTIMO) begin
                    ultimo     = 1'b1;
                    estado_sig = FIN;
                end
            end
            FIN: begin
                valido     = 1'b1;
                estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            x_q   <= ESTADO_INI;
            p_x_q <= 1'b0;
        end else if (acepta) begin
            a_q <= a_p;
            b_q <= b_p;
            cnt <= '0;
            x_q <= ESTADO_INI;
        end else if (estado == CALCULO) begin
            a_q <= a_q >> PASO;
            b_q <= b_q >> PASO;
            cnt <= cnt + CW'(1);
            x_q <= x_sig;
            // Result register is loaded on the last slice so it is already
            // valid during FIN and then holds until the next operation ends.
            if (ultimo) p_x_q <= x_sig;
        end
    end

    assign p_x = p_x_q;

`ifdef COMPARADOR_IGUAL_EN
    logic eq_q, eq_sig, igual_q;

    assign eq_sig = eq_q & (a_q[PASO-1:0] == b_q[PASO-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q    <= 1'b1;
            igual_q <= 1'b0;
        end else if (acepta) begin
            eq_q <= 1'b1;
        end else if (estado == CALCULO) begin
            eq_q <= eq_sig;
            if (ultimo) igual_q <= eq_sig;
        end
    end

    assign igual = igual_q;
`else
    assign igual = 1'b0;
`endif

endmodule

// File: tb/tb_comparador_serie_d_i.sv
// tb_comparador_serie_d_i
// Directed bench for comparador_serie_d_i using three instances:
//   d0: ANCHO=8 PASO=1 ESTADO_INI=0
//   d1: ANCHO=8 PASO=1 ESTADO_INI=1
//   d2: ANCHO=8 PASO=4 ESTADO_INI=0
// Expected igual follows COMPARADOR_IGUAL_EN.
module tb_comparador_serie_d_i;

`ifdef COMPARADOR_IGUAL_EN
    localparam logic IG_EQ = 1'b1;
`else
    localparam logic IG_EQ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0] inicio;
    logic [7:0] a_p [3];
    logic [7:0] b_p [3];
    logic [2:0] listo, valido, p_x, igual;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    comparador_serie_d_i #(.ANCHO(8), .PASO(1), .ESTADO_INI(1'b0)) d0 (
        .clk(clk), .rst(rst), .inicio(inicio[0]), .a_p(a_p[0]), .b_p(b_p[0]),
        .listo(listo[0]), .valido(valido[0]), .p_x(p_x[0]), .igual(igual[0]));

    comparador_serie_d_i #(.ANCHO(8), .PASO(1), .ESTADO_INI(1'b1)) d1 (
        .clk(clk), .rst(rst), .inicio(inicio[1]), .a_p(a_p[1]), .b_p(b_p[1]),
        .listo(listo[1]), .valido(valido[1]), .p_x(p_x[1]), .igual(igual[1]));

    comparador_serie_d_i #(.ANCHO(8), .PASO(4), .ESTADO_INI(1'b0)) d2 (
        .clk(clk), .rst(rst), .inicio(inicio[2]), .a_p(a_p[2]), .b_p(b_p[2]),
        .listo(listo[2]), .valido(valido[2]), .p_x(p_x[2]), .igual(igual[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_in(input int sel, input logic [7:0] a, input logic [7:0] b, input logic go);
        a_p[sel]    = a;
        b_p[sel]    = b;
        inicio[sel] = go;
    endtask

    // Starts an operation from REPOSO (called at a falling edge), measures the
    // number of rising edges until valido, and checks result, pulse width and
    // that listo stayed low throughout. Returns at a falling edge in REPOSO.
    task automatic op(input string tag, input int sel, input logic [7:0] a, input logic [7:0] b,
                      input bit intrude, input int exp_lat, input logic exp_px, input logic exp_ig);
        int   lat;
        logic px, ig;
        bit   listo_bad;
        lat = -1; px = 1'bx; ig = 1'bx; listo_bad = 1'b0;
        set_in(sel, a, b, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (i == 1) set_in(sel, a, b, 1'b0);
            if (intrude && i == 2) set_in(sel, ~a, ~b, 1'b1);
            if (intrude && i == 3) set_in(sel, ~a, ~b, 1'b0);
            if (valido[sel]) begin
                lat = i; px = p_x[sel]; ig = igual[sel];
                break;
            end
            if (listo[sel]) listo_bad = 1'b1;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_px"}, px, exp_px);
        chk({tag, "_igual"}, ig, exp_ig);
        chk({tag, "_listo_low"}, listo_bad, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_valido_1cyc"}, valido[sel], 1'b0);
        chk({tag, "_px_hold"}, p_x[sel], exp_px);
        @(negedge clk);
    endtask

    initial begin
        int pulses [4];
        int np;
        bit seen;

        inicio = '0;
        for (int s = 0; s < 3; s++) set_in(s, 8'h00, 8'h00, 1'b0);

        // Reset state
        #2;
        chk("rst_listo", listo, 3'b111);
        chk("rst_valido", valido, 3'b000);
        chk("rst_px", p_x, 3'b000);
        chk("rst_igual", igual, 3'b000);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_listo", listo, 3'b111);

        // Main function
        op("d0_05_07", 0, 8'h05, 8'h07, 1'b0, 9, 1'b1, 1'b0);
        op("d0_00_00", 0, 8'h00, 8'h00, 1'b0, 9, 1'b0, IG_EQ);
        op("d0_07_05", 0, 8'h07, 8'h05, 1'b0, 9, 1'b0, 1'b0);
        op("d0_80_7F", 0, 8'h80, 8'h7F, 1'b0, 9, 1'b0, 1'b0);
        op("d0_7F_80", 0, 8'h7F, 8'h80, 1'b0, 9, 1'b1, 1'b0);
        op("d0_FF_FF", 0, 8'hFF, 8'hFF, 1'b0, 9, 1'b0, IG_EQ);
        op("d1_3C_3C", 1, 8'h3C, 8'h3C, 1'b0, 9, 1'b1, IG_EQ);
        op("d1_80_7F", 1, 8'h80, 8'h7F, 1'b0, 9, 1'b0, 1'b0);
        op("d1_00_00", 1, 8'h00, 8'h00, 1'b0, 9, 1'b1, IG_EQ);
        op("d1_01_00", 1, 8'h01, 8'h00, 1'b0, 9, 1'b0, 1'b0);
        op("d2_FF_00", 2, 8'hFF, 8'h00, 1'b0, 3, 1'b0, 1'b0);
        op("d2_12_34", 2, 8'h12, 8'h34, 1'b0, 3, 1'b1, 1'b0);
        op("d2_A5_A5", 2, 8'hA5, 8'hA5, 1'b0, 3, 1'b0, IG_EQ);

        // inicio while busy is ignored: second request would give p_x=0
        op("d0_busy", 0, 8'h01, 8'h02, 1'b1, 9, 1'b1, 1'b0);

        // Asynchronous reset in the 4th CALCULO cycle
        set_in(0, 8'h55, 8'hAA, 1'b1);
        @(posedge clk); #1;
        set_in(0, 8'h55, 8'hAA, 1'b0);
        for (int i = 0; i < 3; i++) begin @(posedge clk); end
        #2;
        chk("mid_listo_before", listo[0], 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_listo_async", listo[0], 1'b1);
        chk("mid_px_reset", p_x[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (valido[0]) seen = 1'b1;
        end
        chk("mid_no_valido", seen, 1'b0);
        @(negedge clk);
        op("d0_10_01", 0, 8'h10, 8'h01, 1'b0, 9, 1'b0, 1'b0);

        // Back-to-back with inicio held high: pulses every 10 cycles
        np = 0;
        set_in(0, 8'h03, 8'h09, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valido[0]) begin
                if (np < 4) pulses[np] = i;
                np++;
            end
        end
        set_in(0, 8'h03, 8'h09, 1'b0);
        chk("b2b_count", np, 4);
        chk("b2b_first", pulses[0], 9);
        chk("b2b_gap1", pulses[1] - pulses[0], 10);
        chk("b2b_gap2", pulses[2] - pulses[1], 10);
        chk("b2b_px", p_x[0], 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
